// File: rtl/fpga_exit_reporter.sv
// fpga_exit_reporter
//
// Watches the core's exit-valid/exit-value pair. On the rising edge of
// exit_valid_i it latches the 32-bit exit code, sets the pass/fail LEDs and
// sends the line "EXIT=XXXXXXXX\r\n" (uppercase hex, MSB nibble first) on an
// 8N1 UART pin.
//
// Ports
//   clk_i         system clock
//   rst_i         synchronous reset, active-high
//   exit_valid_i  exit-valid level from the core
//   exit_value_i  32-bit exit code, latched on the capture cycle
//   uart_tx_o     8N1 serial output, LSB first, idles high
//   busy_o        high while the status line is being sent
//   done_o        one-cycle pulse after the last stop bit
//   pass_led_o    last captured value was zero
//   fail_led_o    last captured value was non-zero
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | line idle, waiting for a rising edge of exit_valid_i
// START | start bit (low) of the current byte
// DATA  | data bits of the current byte, LSB first
// STOP  | stop bit (high); then next byte or back to IDLE

module fpga_exit_reporter #(
    parameter int CLKS_PER_BIT = 130
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_led_o,
    output logic        fail_led_o
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    BYTE_LAST = 4'd14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_valid_q;
    logic [31:0]   r_value, w_value_nxt;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [3:0]    r_byte_idx, w_byte_idx_nxt;
    logic          r_tx, w_tx_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;
    logic          r_pass, w_pass_nxt;
    logic          r_fail, w_fail_nxt;

    logic          w_capture;
    logic          w_bit_end;
    logic [3:0]    w_nib_sel;
    logic [3:0]    w_nib;
    logic [7:0]    w_hex;
    logic [7:0]    w_char;

    assign w_capture = exit_valid_i && !r_valid_q && (r_state == IDLE);
    assign w_bit_end = (r_clk_cnt == CNT_LAST);

    // Bytes 5..12 carry nibbles 7..0 of the latched value.
    assign w_nib_sel = 4'd12 - r_byte_idx;
    assign w_nib     = r_value[{w_nib_sel[2:0], 2'b00} +: 4];
    assign w_hex     = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                       : (8'h37 + {4'h0, w_nib});

    always_comb begin
        w_char = w_hex;
        case (r_byte_idx)
            4'd0:    w_char = 8'h45;
            4'd1:    w_char = 8'h58;
            4'd2:    w_char = 8'h49;
            4'd3:    w_char = 8'h54;
            4'd4:    w_char = 8'h3D;
            4'd13:   w_char = 8'h0D;
            4'd14:   w_char = 8'h0A;
            default: w_char = w_hex;
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_value_nxt    = r_value;
        w_clk_cnt_nxt  = r_clk_cnt;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        w_tx_nxt       = r_tx;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_fail_nxt     = r_fail;

        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_value_nxt    = exit_value_i;
                    w_pass_nxt     = (exit_value_i == 32'd0);
                    w_fail_nxt     = (exit_value_i != 32'd0);
                    w_state_nxt    = START;
                    w_clk_cnt_nxt  = '0;
                    w_bit_idx_nxt  = 3'd0;
                    w_byte_idx_nxt = 4'd0;
                    w_tx_nxt       = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                    w_tx_nxt      = w_char[0];
                    w_state_nxt   = DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        w_tx_nxt      = w_char[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_nxt = '0;
                    if (r_byte_idx < BYTE_LAST) begin
                        // Next byte starts immediately, no idle gap.
                        w_byte_idx_nxt = r_byte_idx + 4'd1;
                        w_tx_nxt       = 1'b0;
                        w_state_nxt    = START;
                    end else begin
                        w_byte_idx_nxt = 4'd0;
                        w_tx_nxt       = 1'b1;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = IDLE;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_valid_q  <= 1'b0;
            r_value    <= 32'd0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 4'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid_q  <= exit_valid_i;
            r_value    <= w_value_nxt;
            r_clk_cnt  <= w_clk_cnt_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_fail     <= w_fail_nxt;
        end
    end

    assign uart_tx_o  = r_tx;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign pass_led_o = r_pass;
    assign fail_led_o = r_fail;

endmodule

// File: tb/tb_fpga_exit_reporter.sv
module tb_fpga_exit_reporter;

    localparam int CPB = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        uart_tx_o;
    logic        busy_o;
    logic        done_o;
    logic        pass_led_o;
    logic        fail_led_o;

    int total = 0;
    int bad   = 0;
    int n_lines = 0;

    logic [7:0] sb[$];

    fpga_exit_reporter #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .uart_tx_o    (uart_tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .pass_led_o   (pass_led_o),
        .fail_led_o   (fail_led_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h41 + {4'h0, n} - 8'd10;
    endfunction

    task automatic push_line(input logic [31:0] v);
        sb.push_back(8'h45); sb.push_back(8'h58); sb.push_back(8'h49);
        sb.push_back(8'h54); sb.push_back(8'h3D);
        for (int i = 7; i >= 0; i--) sb.push_back(hex_char(v[i*4 +: 4]));
        sb.push_back(8'h0D); sb.push_back(8'h0A);
    endtask

    // UART monitor: grabs a whole 10-bit frame cycle by cycle, abandons it on reset.
    initial begin : uart_mon
        logic       prev;
        logic       smp [0:10*CPB-1];
        logic       abort;
        logic       refb;
        logic [7:0] rx;
        logic [7:0] expb;
        int         shape_bad;
        prev = 1'b1;
        forever begin
            @(negedge clk_i);
            if (!rst_i && prev === 1'b1 && uart_tx_o === 1'b0) begin
                abort  = 1'b0;
                smp[0] = uart_tx_o;
                for (int s = 1; s < 10*CPB; s++) begin
                    @(negedge clk_i);
                    if (rst_i) begin
                        abort = 1'b1;
                        break;
                    end
                    smp[s] = uart_tx_o;
                end
                if (!abort) begin
                    shape_bad = 0;
                    rx = 8'h00;
                    for (int b = 0; b < 10; b++) begin
                        if (b == 0)      refb = 1'b0;
                        else if (b == 9) refb = 1'b1;
                        else             refb = smp[b*CPB];
                        if (b >= 1 && b <= 8) rx[b-1] = smp[b*CPB];
                        for (int s = 0; s < CPB; s++)
                            if (smp[b*CPB + s] !== refb) shape_bad++;
                    end
                    chk("frame_shape", shape_bad, 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_byte", {24'h0, rx}, 32'hFFFF_FFFF);
                    end else begin
                        expb = sb.pop_front();
                        chk("rx_byte", {24'h0, rx}, {24'h0, expb});
                    end
                    if (rx == 8'h0A) n_lines++;
                end
            end
            prev = uart_tx_o;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

    task automatic drive_point();
        @(posedge clk_i);
        #1;
    endtask

    // Entered at the first busy negedge; counts busy cycles and checks done/LEDs.
    task automatic track_busy(input logic exp_pass, input bit do_toggle);
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 2000) begin
            n++;
            if (do_toggle) begin
                case (n)
                    50: begin exit_valid_i = 1'b0; exit_value_i = 32'h1; end
                    60: exit_valid_i = 1'b1;
                    70: exit_valid_i = 1'b0;
                    80: exit_valid_i = 1'b1;
                    default: ;
                endcase
            end
            @(negedge clk_i);
        end
        chk("busy_len", n, 150*CPB);
        chk("done_pulse", done_o, 1);
        chk("pass_led", pass_led_o, exp_pass);
        chk("fail_led", fail_led_o, !exp_pass);
        @(negedge clk_i);
        chk("done_single", done_o, 0);
    endtask

    task automatic send_line(input logic [31:0] v, input bit do_toggle);
        drive_point();
        exit_valid_i = 1'b0;
        repeat (2) drive_point();
        exit_value_i = v;
        exit_valid_i = 1'b1;
        push_line(v);
        @(negedge clk_i);
        chk("capture_tx_idle", uart_tx_o, 1);
        @(negedge clk_i);
        chk("start_latency", uart_tx_o, 0);
        chk("busy_rise", busy_o, 1);
        chk("led_update", pass_led_o, (v == 32'd0));
        track_busy(v == 32'd0, do_toggle);
    endtask

    initial begin : main
        int l0;
        bit busy_seen;
        rst_i        = 1'b1;
        exit_valid_i = 1'b0;
        exit_value_i = 32'h0;
        repeat (3) drive_point();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_tx", uart_tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_led_o, 0);
        chk("rst_fail", fail_led_o, 0);

        send_line(32'h0000_002A, 1'b0);
        send_line(32'h0000_0000, 1'b0);
        send_line(32'hDEAD_BEEF, 1'b0);

        // Edges during busy are ignored; the level stays high afterwards.
        send_line(32'h0000_002A, 1'b1);
        l0 = n_lines;
        busy_seen = 1'b0;
        repeat (1400) begin
            @(negedge clk_i);
            if (busy_o === 1'b1) busy_seen = 1'b1;
        end
        chk("hold_no_busy", busy_seen, 0);
        chk("hold_lines", n_lines - l0, 0);
        chk("hold_sb_empty", sb.size(), 0);

        // Reset during the 3rd byte's data bits with exit_valid_i still high.
        drive_point();
        exit_valid_i = 1'b0;
        repeat (2) drive_point();
        exit_value_i = 32'h1234_5678;
        exit_valid_i = 1'b1;
        push_line(32'h1234_5678);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("mid_start", uart_tx_o, 0);
        repeat (89) @(negedge clk_i);
        drive_point();
        rst_i = 1'b1;
        drive_point();
        rst_i = 1'b0;
        sb.delete();
        push_line(32'h1234_5678);
        @(negedge clk_i);
        chk("mid_rst_tx", uart_tx_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_pass", pass_led_o, 0);
        chk("mid_rst_fail", fail_led_o, 0);
        @(negedge clk_i);
        chk("mid_restart_tx", uart_tx_o, 0);
        chk("mid_restart_busy", busy_o, 1);
        track_busy(1'b0, 1'b0);

        // Capture on the first cycle after reset release.
        drive_point();
        rst_i        = 1'b1;
        exit_value_i = 32'hCAFE_0001;
        drive_point();
        rst_i = 1'b0;
        push_line(32'hCAFE_0001);
        @(negedge clk_i);
        chk("rel_tx_idle", uart_tx_o, 1);
        chk("rel_busy_low", busy_o, 0);
        @(negedge clk_i);
        chk("rel_start", uart_tx_o, 0);
        chk("rel_busy", busy_o, 1);
        track_busy(1'b0, 1'b0);

        repeat (4) @(negedge clk_i);
        chk("lines_total", n_lines, 6);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
